// File: rtl/isquare_pkg.sv
// isquare_pkg: shared state encoding, default widths and counter sizing for isquare
package isquare_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int Y_WIDTH_DEF = 16;
   localparam int X_WIDTH_DEF = 32;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/isquare_check.sv
// isquare_check: y == floor(sqrt(x_ref)) range compare, sq <= x_ref <= sq + 2*y
`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
module isquare_check #(
   parameter int Y_WIDTH = 16,
   parameter int X_WIDTH = 32
) (
   input  logic [X_WIDTH-1:0] sq,
   input  logic [Y_WIDTH-1:0] y,
   input  logic [X_WIDTH-1:0] x_ref,
   output logic               ok_d
);
   localparam int W = X_WIDTH + 1;
   logic [W-1:0] lo, hi, r;
   always_comb begin
      lo   = W'(sq);
      r    = W'(x_ref);
      hi   = lo + (W'(y) << 1);
      ok_d = (lo <= r) && (r <= hi);
   end
endmodule
`endif

// File: rtl/isquare.sv
// isquare: sequential shift-and-add squarer x = y*y, one result per Y_WIDTH+1 cycles
// ISQUARE_ROUNDTRIP_CHECK_EN adds x_ref/ok round-trip check of the result against a sqrt input
module isquare
   import isquare_pkg::*;
#(
   parameter int Y_WIDTH = Y_WIDTH_DEF,
   parameter int X_WIDTH = X_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [Y_WIDTH-1:0] y,
   input  logic               en,
   output logic [X_WIDTH-1:0] x,
   output logic               busy,
   output logic               dav
`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
   ,
   input  logic [X_WIDTH-1:0] x_ref,
   output logic               ok
`endif
);
   localparam int CW = (clog2(Y_WIDTH) < 1) ? 1 : clog2(Y_WIDTH);

   if (X_WIDTH != 2 * Y_WIDTH) begin : g_width_bad
      $error("isquare: X_WIDTH must equal 2*Y_WIDTH");
   end

   state_t             state;
   logic [X_WIDTH-1:0] mcand, acc, sum;
   logic [Y_WIDTH-1:0] mplier;
   logic [CW-1:0]      cnt;

   // mcand is pre-shifted each iteration, so it already holds y<<k
   always_comb sum = acc + (mplier[0] ? mcand : '0);

`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
   logic [Y_WIDTH-1:0] y_r;
   logic [X_WIDTH-1:0] xref_r;
   logic               ok_d;

   isquare_check #(.Y_WIDTH(Y_WIDTH), .X_WIDTH(X_WIDTH)) u_check (
      .sq   (sum),
      .y    (y_r),
      .x_ref(xref_r),
      .ok_d (ok_d)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         y_r    <= '0;
         xref_r <= '0;
         ok     <= 1'b0;
      end else if (en) begin
         y_r    <= y;
         xref_r <= x_ref;
      end else if (state == RUN && cnt == '0) begin
         ok     <= ok_d;
      end
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         x      <= '0;
         busy   <= 1'b0;
         dav    <= 1'b0;
      end else if (en) begin
         state  <= RUN;
         mcand  <= X_WIDTH'(y);
         mplier <= y;
         acc    <= '0;
         cnt    <= CW'(Y_WIDTH - 1);
         busy   <= 1'b1;
         dav    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               acc    <= sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  x     <= sum;
                  state <= DONE;
                  dav   <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               dav   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_isquare.sv
// tb_isquare: directed and random scoreboard bench for isquare
module tb_isquare;
   localparam int YW = 16;
   localparam int XW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [YW-1:0] y = '0;
   logic [XW-1:0] x;
   logic          busy, dav;
   logic [XW-1:0] x_ref = '0;
`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
   logic          ok;
`endif

   int tests = 0, fails = 0, cyc = 0, ndav = 0;

   typedef struct {
      logic [XW-1:0] x;
      int            c;
      logic          ok;
   } exp_t;
   exp_t q[$];

   isquare #(.Y_WIDTH(YW), .X_WIDTH(XW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .y    (y),
      .en   (en),
      .x    (x),
      .busy (busy),
      .dav  (dav)
`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
      ,
      .x_ref(x_ref),
      .ok   (ok)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, o, e);
      end
   endtask

   // every dav must match the oldest outstanding, uncancelled operation
   always @(negedge clk)
      if (dav) begin
         exp_t e;
         ndav++;
         if (q.size() == 0) chk("unexpected dav", 64'd1, 64'd0);
         else begin
            e = q.pop_front();
            chk("x", 64'(x), 64'(e.x));
            chk("latency", 64'(cyc), 64'(e.c));
`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
            chk("ok", 64'(ok), 64'(e.ok));
`endif
         end
      end

   function automatic exp_t model(input logic [YW-1:0] v, input logic [XW-1:0] r, input int c);
      exp_t   e;
      longint s = longint'(v) * longint'(v);
      e.x  = XW'(s);
      e.c  = c;
      e.ok = (s <= longint'(r)) && (longint'(r) <= s + 2 * longint'(v));
      return e;
   endfunction

   // a new en cancels whatever is pending, so the scoreboard is reset too
   task automatic go(input logic [YW-1:0] v, input logic [XW-1:0] r, input bit now);
      if (now) #1;
      else @(negedge clk);
      y = v;
      x_ref = r;
      en = 1'b1;
      q.delete();
      q.push_back(model(v, r, cyc + 17));
      @(posedge clk);
      #1 en = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " timeout"}, 64'(q.size() == 0), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, n;
      logic [YW-1:0] vs[3];
      logic [XW-1:0] xs[3];
      vs = '{16'h0000, 16'hFFFF, 16'h8000};
      xs = '{32'h0, 32'hFFFE0001, 32'h40000000};

      #1;
      chk("reset x", 64'(x), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset dav", 64'(dav), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle busy", 64'(busy), 64'd0);

      d = ndav;
      go(16'd3, 32'd9, 0);
      @(negedge clk);
      chk("busy c1", 64'(busy), 64'd1);
      repeat (15) @(negedge clk);
      chk("busy c16", 64'(busy), 64'd1);
      chk("dav c16", 64'(dav), 64'd0);
      @(negedge clk);
      chk("busy c17", 64'(busy), 64'd0);
      chk("dav c17", 64'(dav), 64'd1);
      chk("x=9", 64'(x), 64'd9);
      repeat (3) @(negedge clk);
      chk("dav once 3", 64'(ndav), 64'(d + 1));

      for (int i = 0; i < 3; i++) begin
         d = ndav;
         go(vs[i], '0, 0);
         wait_done("edge");
         repeat (3) @(negedge clk);
         chk("edge x", 64'(x), 64'(xs[i]));
         chk("edge dav once", 64'(ndav), 64'(d + 1));
      end

      d = ndav;
      go(16'd100, '0, 0);
      chk("x held in run", 64'(x), 64'h40000000);
      repeat (3) @(negedge clk);
      go(16'd7, '0, 0);
      chk("x held after cancel", 64'(x), 64'h40000000);
      wait_done("cancel");
      repeat (3) @(negedge clk);
      chk("cancel x", 64'(x), 64'd49);
      chk("cancel dav once", 64'(ndav), 64'(d + 1));

      go(16'd1234, '0, 0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      chk("async x", 64'(x), 64'd0);
      chk("async busy", 64'(busy), 64'd0);
      chk("async dav", 64'(dav), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d = ndav;
      repeat (30) @(negedge clk);
      chk("no dav after reset", 64'(ndav), 64'(d));
      chk("idle after reset", 64'(busy), 64'd0);

      go(16'd500, '0, 0);
      n = 0;
      while (!dav && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b first done", 64'(dav), 64'd1);
      go(16'd77, '0, 1);
      chk("b2b dav drop", 64'(dav), 64'd0);
      chk("b2b busy", 64'(busy), 64'd1);
      wait_done("b2b");
      chk("b2b x", 64'(x), 64'd5929);

      @(negedge clk);
      y = 16'd9;
      en = 1'b1;
      q.delete();
      d = ndav;
      repeat (20) @(negedge clk);
      chk("held en no dav", 64'(ndav), 64'(d));
      chk("held en busy", 64'(busy), 64'd1);
      q.push_back(model(16'd9, '0, cyc + 16));
      en = 1'b0;
      wait_done("held en");
      chk("held en x", 64'(x), 64'd81);

`ifdef ISQUARE_ROUNDTRIP_CHECK_EN
      go(16'd3, 32'd15, 0);
      wait_done("rt 15");
      chk("rt 3/15", 64'(ok), 64'd1);
      go(16'd3, 32'd16, 0);
      wait_done("rt 16");
      chk("rt 3/16", 64'(ok), 64'd0);
      go(16'd3, 32'd8, 0);
      wait_done("rt 8");
      chk("rt 3/8", 64'(ok), 64'd0);
      go(16'hFFFF, 32'hFFFFFFFF, 0);
      wait_done("rt max");
      chk("rt max", 64'(ok), 64'd1);
`endif

      for (int i = 0; i < 1000; i++) begin
         logic [YW-1:0] v;
         logic [XW-1:0] r;
         v = YW'($urandom);
         r = XW'(longint'(v) * longint'(v) + longint'($urandom_range(0, 2 * v + 1)));
         if (i % 7 == 0) r = XW'($urandom);
         go(v, r, 0);
         wait_done("random");
      end

      repeat (3) @(negedge clk);
      chk("scoreboard empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
